word_deserializer: RTL and testbench
====================================

# word_deserializer

Parametrised multi-lane serial-to-parallel converter for the XOR-cipher datapath, successor to the single-bit key/data deserializer. Accepts LANES bits per enabled cycle, assembles DATA_SIZE-bit words in a configurable bit order, and presents each completed word on a valid/ready output. Completed words are held stable until consumed, and beats that arrive while no space is available are flagged. Sits between the pin-level input sampler and the cipher core's key/plaintext registers.

## Interface
Parameters:
- DATA_SIZE, 32, word width in bits; must be a multiple of LANES.
- LANES, 1, bits accepted per beat; legal values 1, 2, 4, 8.
- MSB_FIRST, 1, 1 = first beat lands in the word's MSBs; 0 = first beat lands in the LSBs.

Ports:
- iClk  input  1  clock; all logic on rising edge.
- iRst  input  1  reset, synchronous, active-high.
- iEn  input  1  beat strobe; a beat is presented when iEn && iLoading.
- iLoading  input  1  loading-mode qualifier; low pauses assembly without losing state.
- iData_in  input  LANES  beat data; iData_in[LANES-1] is the most significant bit within the beat.
- iReady  input  1  consumer accepts the word held on oData.
- oData  output  DATA_SIZE  last completed word; changes only on word completion.
- oValid  output  1  oData holds an unconsumed word.
- oBit_counter  output  $clog2(DATA_SIZE)+1  bits currently assembled, range 0..DATA_SIZE.
- oOverrun  output  1  sticky flag: a beat was dropped.

## Operation
- Internal shift register shreg[DATA_SIZE-1:0]; beat count cnt, incremented by LANES per beat.
- States:
  - LOAD: accept beats.
  - FULL: word waiting for iReady.
- Shift rule:
  - MSB_FIRST=1: shreg <= {shreg[DATA_SIZE-LANES-1:0], iData_in}.
  - MSB_FIRST=0: shreg <= {iData_in, shreg[DATA_SIZE-1:LANES]}.
- In LOAD, when a beat makes cnt reach DATA_SIZE: oData <= the shifted word, oValid <= 1, cnt <= 0, state -> FULL.
- In FULL with iReady=1: oValid <= 0, state -> LOAD. If a beat is also present that cycle, it is accepted as beat 1 of the next word (cnt = LANES).
- In FULL with iReady=0: any presented beat is dropped and oOverrun <= 1. shreg, cnt and oData are unchanged.
- iLoading=0 mid-word: shreg and cnt are held; assembly resumes on the next beat. No abort.
- oBit_counter = DATA_SIZE in FULL, otherwise cnt.
- oOverrun clears only on reset.
- Reset values:
  - oData = 0, oValid = 0, oBit_counter = 0, oOverrun = 0.
  - shreg = 0, cnt = 0, state = LOAD.
- Reset dominates all other inputs, including mid-word and in FULL.

## Timing
- Word latency: oValid rises on the clock edge that samples the final beat, i.e. visible in the following cycle. Minimum DATA_SIZE/LANES beats per word.
- Handshake: a transfer occurs on each edge where oValid && iReady. iReady while oValid=0 is ignored.
- Sustained throughput: one beat per cycle with no loss, provided iReady is high on every cycle in FULL (zero bubble).
- oData is stable for the entire time oValid=1.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- WORD_DESER_PARITY_EN defined:
  - Adds input iParity (1 bit), sampled with the completing beat.
  - Adds output oParity_err (1 bit, reset 0), registered alongside oData: oParity_err = ^word ^ iParity (even parity; 1 = error).
  - oParity_err updates on every word completion and is held while in FULL.
- WORD_DESER_PARITY_EN undefined: neither port exists, and no parity logic is built.

## Test plan
- Order, MSB_FIRST=1, LANES=1, DATA_SIZE=32: shift the bits of 0xA5C3_0F96, MSB first, one per cycle, with iReady=0 -> oValid=1 one cycle after bit 32, oData=0xA5C3_0F96, oBit_counter=32.
- Order, MSB_FIRST=0, LANES=4: send nibbles 6,9,F,0,3,C,5,A in that order -> oData=0xA5C3_0F96.
- Back-to-back, LANES=8, iReady=1 constantly: 8 consecutive beats 0x11..0x88 -> words 0x11223344 then 0x55667788, no gap cycle, oOverrun=0.
- Overrun: complete a word, hold iReady=0, then send one beat -> oOverrun=1, oData unchanged, oBit_counter=32. Then iReady=1 -> oValid=0, oOverrun stays 1.
- Pause and reset: after 12 of 32 bits, drop iLoading for 5 cycles -> oBit_counter holds at 12; finishing the remaining 20 bits gives the correct word. Asserting iRst at bit 20 of a later word -> all outputs 0 the next cycle.
- Parity (macro defined): word 0x0000_0001 with iParity=1 -> oParity_err=0; the same word with iParity=0 -> oParity_err=1.

Source files
------------

// File: rtl/word_deserializer.sv
// Multi-lane serial-to-parallel word assembler with a valid/ready output and a sticky overrun flag.
// Optional even-parity check on each completed word when WORD_DESER_PARITY_EN is defined.
`timescale 1ns/1ps

module word_deserializer #(
    parameter int DATA_SIZE = 32,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic                        iEn,
    input  logic                        iLoading,
    input  logic [LANES-1:0]            iData_in,
    input  logic                        iReady,
`ifdef WORD_DESER_PARITY_EN
    input  logic                        iParity,
    output logic                        oParity_err,
`endif
    output logic [DATA_SIZE-1:0]        oData,
    output logic                        oValid,
    output logic [$clog2(DATA_SIZE):0]  oBit_counter,
    output logic                        oOverrun
);

    localparam int            CW      = $clog2(DATA_SIZE) + 1;
    localparam logic [CW-1:0] LANES_C = CW'(LANES);
    localparam logic [CW-1:0] DATA_C  = CW'(DATA_SIZE);

    typedef enum logic {
        S_LOAD,
        S_FULL
    } state_t;

    state_t               r_state, w_state_next;
    logic [DATA_SIZE-1:0] r_shreg, w_shreg_next, w_shifted;
    logic [DATA_SIZE-1:0] r_data, w_data_next;
    logic [CW-1:0]        r_cnt, w_cnt_next, r_bit_counter, w_bit_counter_next;
    logic                 r_valid, w_valid_next;
    logic                 r_overrun, w_overrun_next;
    logic                 w_beat, w_accept, w_done;

    assign w_beat   = iEn && iLoading;
    // In FULL a beat is only taken when the held word leaves on the same edge.
    assign w_accept = w_beat && ((r_state == S_LOAD) || iReady);
    assign w_done   = w_accept && ((r_cnt + LANES_C) == DATA_C);

    generate
        if (LANES == DATA_SIZE) begin : g_single_beat
            logic w_unused_shreg;
            assign w_unused_shreg = ^r_shreg;
            assign w_shifted      = iData_in;
        end else if (MSB_FIRST) begin : g_msb_first
            logic w_unused_top;
            assign w_unused_top = ^r_shreg[DATA_SIZE-1:DATA_SIZE-LANES];
            assign w_shifted    = {r_shreg[DATA_SIZE-LANES-1:0], iData_in};
        end else begin : g_lsb_first
            logic w_unused_bottom;
            assign w_unused_bottom = ^r_shreg[LANES-1:0];
            assign w_shifted       = {iData_in, r_shreg[DATA_SIZE-1:LANES]};
        end
    endgenerate

    // NOTE: every signal gets its hold value first so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_state_next   = r_state;
        w_shreg_next   = r_shreg;
        w_cnt_next     = r_cnt;
        w_data_next    = r_data;
        w_valid_next   = r_valid;
        w_overrun_next = r_overrun;

        if (r_state == S_FULL) begin
            if (iReady) begin
                w_valid_next = 1'b0;
                w_state_next = S_LOAD;
            end else if (w_beat) begin
                w_overrun_next = 1'b1;
            end
        end

        // cnt is zero in FULL, so a beat accepted there starts the next word.
        if (w_accept) begin
            w_shreg_next = w_shifted;
            if (w_done) begin
                w_cnt_next   = '0;
                w_data_next  = w_shifted;
                w_valid_next = 1'b1;
                w_state_next = S_FULL;
            end else begin
                w_cnt_next = r_cnt + LANES_C;
            end
        end

        w_bit_counter_next = (w_state_next == S_FULL) ? DATA_C : w_cnt_next;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_shreg       <= '0;
            r_cnt         <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_overrun     <= 1'b0;
            r_bit_counter <= '0;
        end else begin
            r_shreg       <= w_shreg_next;
            r_cnt         <= w_cnt_next;
            r_data        <= w_data_next;
            r_valid       <= w_valid_next;
            r_overrun     <= w_overrun_next;
            r_bit_counter <= w_bit_counter_next;
        end
    end

`ifdef WORD_DESER_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_parity_err <= 1'b0;
        end else if (w_done) begin
            r_parity_err <= (^w_shifted) ^ iParity;
        end
    end

    assign oParity_err = r_parity_err;
`endif

    assign oData        = r_data;
    assign oValid       = r_valid;
    assign oBit_counter = r_bit_counter;
    assign oOverrun     = r_overrun;

endmodule

// File: tb/tb_word_deserializer.sv
// Directed bench for word_deserializer: bit order, back-to-back words, overrun, pause and reset.
// Three instances cover LANES=1/MSB-first, LANES=4/LSB-first and LANES=8 with iReady tied high.
`timescale 1ns/1ps

module tb_word_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic rst;

    // LANES=1, MSB_FIRST=1
    logic        m_en, m_ld, m_din, m_rdy;
    logic [31:0] m_data;
    logic        m_valid, m_ovr;
    logic [5:0]  m_cnt;

    // LANES=4, MSB_FIRST=0
    logic        l_en, l_ld, l_rdy;
    logic [3:0]  l_din;
    logic [31:0] l_data;
    logic        l_valid, l_ovr;
    logic [5:0]  l_cnt;

    // LANES=8, MSB_FIRST=1
    logic        b_en, b_ld, b_rdy;
    logic [7:0]  b_din;
    logic [31:0] b_data;
    logic        b_valid, b_ovr;
    logic [5:0]  b_cnt;

`ifdef WORD_DESER_PARITY_EN
    logic m_par, m_perr, l_perr, b_perr;
`endif

    word_deserializer #(.DATA_SIZE(32), .LANES(1), .MSB_FIRST(1'b1)) u_msb1 (
        .iClk(clk), .iRst(rst), .iEn(m_en), .iLoading(m_ld), .iData_in(m_din), .iReady(m_rdy),
`ifdef WORD_DESER_PARITY_EN
        .iParity(m_par), .oParity_err(m_perr),
`endif
        .oData(m_data), .oValid(m_valid), .oBit_counter(m_cnt), .oOverrun(m_ovr)
    );

    word_deserializer #(.DATA_SIZE(32), .LANES(4), .MSB_FIRST(1'b0)) u_lsb4 (
        .iClk(clk), .iRst(rst), .iEn(l_en), .iLoading(l_ld), .iData_in(l_din), .iReady(l_rdy),
`ifdef WORD_DESER_PARITY_EN
        .iParity(1'b0), .oParity_err(l_perr),
`endif
        .oData(l_data), .oValid(l_valid), .oBit_counter(l_cnt), .oOverrun(l_ovr)
    );

    word_deserializer #(.DATA_SIZE(32), .LANES(8), .MSB_FIRST(1'b1)) u_b8 (
        .iClk(clk), .iRst(rst), .iEn(b_en), .iLoading(b_ld), .iData_in(b_din), .iReady(b_rdy),
`ifdef WORD_DESER_PARITY_EN
        .iParity(1'b0), .oParity_err(b_perr),
`endif
        .oData(b_data), .oValid(b_valid), .oBit_counter(b_cnt), .oOverrun(b_ovr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and land 1 ns after it, where outputs are settled and inputs may change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed bits [31-first .. 31-first-n+1] of w into u_msb1, one per cycle.
    task automatic send_msb1(input logic [31:0] w, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            m_en  = 1'b1;
            m_ld  = 1'b1;
            m_din = w[31-i];
            tick();
        end
        m_en = 1'b0;
    endtask

    logic [3:0] nibbles [8];

    initial begin
        nibbles = '{4'h6, 4'h9, 4'hF, 4'h0, 4'h3, 4'hC, 4'h5, 4'hA};
        rst = 1'b1;
        m_en = 1'b0; m_ld = 1'b1; m_din = 1'b0; m_rdy = 1'b0;
        l_en = 1'b0; l_ld = 1'b1; l_din = '0;   l_rdy = 1'b0;
        b_en = 1'b0; b_ld = 1'b1; b_din = '0;   b_rdy = 1'b1;
`ifdef WORD_DESER_PARITY_EN
        m_par = 1'b0;
`endif
        tick();
        tick();
        check("rst_m_data",  m_data,  32'h0);
        check("rst_m_valid", {31'h0, m_valid}, 32'h0);
        check("rst_m_cnt",   {26'h0, m_cnt},   32'h0);
        check("rst_m_ovr",   {31'h0, m_ovr},   32'h0);
        check("rst_l_valid", {31'h0, l_valid}, 32'h0);
        check("rst_b_cnt",   {26'h0, b_cnt},   32'h0);
        rst = 1'b0;

        // Bit order, LANES=1, MSB first, consumer stalled.
        send_msb1(32'hA5C3_0F96, 0, 31);
        check("m_order_valid_b31", {31'h0, m_valid}, 32'h0);
        check("m_order_cnt_b31",   {26'h0, m_cnt},   32'd31);
        send_msb1(32'hA5C3_0F96, 31, 1);
        check("m_order_valid", {31'h0, m_valid}, 32'h1);
        check("m_order_data",  m_data,           32'hA5C3_0F96);
        check("m_order_cnt",   {26'h0, m_cnt},   32'd32);

        // Overrun: one beat while the word waits.
        send_msb1(32'hFFFF_FFFF, 0, 1);
        check("ovr_flag",  {31'h0, m_ovr},   32'h1);
        check("ovr_data",  m_data,           32'hA5C3_0F96);
        check("ovr_cnt",   {26'h0, m_cnt},   32'd32);
        check("ovr_valid", {31'h0, m_valid}, 32'h1);
        m_rdy = 1'b1;
        tick();
        m_rdy = 1'b0;
        check("ovr_consume_valid", {31'h0, m_valid}, 32'h0);
        check("ovr_sticky",        {31'h0, m_ovr},   32'h1);
        check("ovr_consume_cnt",   {26'h0, m_cnt},   32'd0);

        // Pause: 12 bits, iLoading low for 5 cycles, then the remaining 20.
        send_msb1(32'h3C5A_9E17, 0, 12);
        check("pause_cnt12", {26'h0, m_cnt}, 32'd12);
        m_ld = 1'b0;
        m_en = 1'b1;
        m_din = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        m_en = 1'b0;
        check("pause_hold_cnt", {26'h0, m_cnt},   32'd12);
        check("pause_hold_vld", {31'h0, m_valid}, 32'h0);
        send_msb1(32'h3C5A_9E17, 12, 20);
        check("pause_data",  m_data,           32'h3C5A_9E17);
        check("pause_valid", {31'h0, m_valid}, 32'h1);
        m_rdy = 1'b1;
        tick();
        m_rdy = 1'b0;

`ifdef WORD_DESER_PARITY_EN
        m_par = 1'b1;
        send_msb1(32'h0000_0001, 0, 32);
        check("parity_ok",  {31'h0, m_perr}, 32'h0);
        m_rdy = 1'b1;
        tick();
        m_rdy = 1'b0;
        m_par = 1'b0;
        send_msb1(32'h0000_0001, 0, 32);
        check("parity_err", {31'h0, m_perr}, 32'h1);
        m_rdy = 1'b1;
        tick();
        m_rdy = 1'b0;
`endif

        // Reset at bit 20 of a later word clears everything, including the sticky flag.
        send_msb1(32'hDEAD_BEEF, 0, 20);
        check("prerst_cnt", {26'h0, m_cnt}, 32'd20);
        rst  = 1'b1;
        m_en = 1'b1;
        m_rdy = 1'b1;
        tick();
        rst  = 1'b0;
        m_en = 1'b0;
        m_rdy = 1'b0;
        check("midrst_data",  m_data,           32'h0);
        check("midrst_valid", {31'h0, m_valid}, 32'h0);
        check("midrst_cnt",   {26'h0, m_cnt},   32'h0);
        check("midrst_ovr",   {31'h0, m_ovr},   32'h0);
`ifdef WORD_DESER_PARITY_EN
        check("midrst_perr",  {31'h0, m_perr},  32'h0);
`endif

        // LSB-first nibbles.
        for (int i = 0; i < 8; i++) begin
            l_en  = 1'b1;
            l_din = nibbles[i];
            tick();
            if (i == 2) check("l_cnt12", {26'h0, l_cnt}, 32'd12);
        end
        l_en = 1'b0;
        check("l_data",  l_data,           32'hA5C3_0F96);
        check("l_valid", {31'h0, l_valid}, 32'h1);
        check("l_cnt",   {26'h0, l_cnt},   32'd32);

        // Back-to-back bytes with iReady held high.
        for (int i = 0; i < 8; i++) begin
            b_en  = 1'b1;
            b_din = 8'((i + 1) * 17);
            tick();
            if (i == 3) begin
                check("b_w0_valid", {31'h0, b_valid}, 32'h1);
                check("b_w0_data",  b_data,           32'h1122_3344);
                check("b_w0_cnt",   {26'h0, b_cnt},   32'd32);
            end
            if (i == 4) begin
                check("b_w1_start_valid", {31'h0, b_valid}, 32'h0);
                check("b_w1_start_cnt",   {26'h0, b_cnt},   32'd8);
            end
        end
        b_en = 1'b0;
        check("b_w1_valid", {31'h0, b_valid}, 32'h1);
        check("b_w1_data",  b_data,           32'h5566_7788);
        check("b_ovr",      {31'h0, b_ovr},   32'h0);
        tick();
        check("b_consumed", {31'h0, b_valid}, 32'h0);
        check("b_data_held", b_data,          32'h5566_7788);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
